cc_flag_unit: RTL and testbench
===============================

// Module: cc_flag_unit
// PURPOSE
//  Parametrised condition-code unit for the CPU pipeline.
//  - Holds NFLAGS architectural flags, each with its own update-enable mask bit.
//  - Evaluates the 3-bit branch condition, with optional same-cycle bypass of
//    incoming flags.
//  - Provides a DEPTH-entry save/restore LIFO for interrupt/call context.
//  - Sits between the EX-stage ALU flag outputs and the branch-resolve logic.
// PARAMETERS
//  NFLAGS  3  flag width; bit2=N, bit1=V, bit0=Z. Values <3 are illegal (elaboration $error).
//  DEPTH   4  LIFO entries; must be >=1.
//  BYPASS  1  1: cond_true sees this cycle's masked update. 0: registered flags only.
// PORTS
//  clk         in   1                  clock, rising edge
//  rst_n       in   1                  asynchronous reset, active low
//  en          in   1                  pipeline advance; 0 = stall, no flag update
//  upd_mask    in   NFLAGS             per-flag write enable (decode-generated)
//  flags_in    in   NFLAGS             new flag values from ALU
//  cond        in   3                  branch condition code
//  push        in   1                  save current flags to LIFO
//  pop         in   1                  restore flags from LIFO top
//  clr_err     in   1                  clear sticky error bits
//  flags_out   out  NFLAGS             registered architectural flags
//  cond_true   out  1                  condition evaluates true
//  stk_count   out  $clog2(DEPTH+1)    entries in LIFO
//  stk_full    out  1                  stk_count==DEPTH
//  stk_empty   out  1                  stk_count==0
//  err_ovf     out  1                  sticky: push while full
//  err_unf     out  1                  sticky: pop while empty
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - flags_out=0, stk_count=0, err_ovf=0, err_unf=0.
//   - LIFO contents are don't-care.
//   - Outputs are forced low while rst_n=0, independent of clk.
//  Flag update
//   - At the edge, if en & ~pop: flags[i] <= upd_mask[i] ? flags_in[i] : flags[i].
//   - Unmasked flags are preserved, never zeroed.
//   - en=0 holds all flags. Latency 1 cycle.
//  Condition (combinational)
//   - Operand f = (BYPASS & en & ~pop) ? masked-merge(flags, flags_in) : flags.
//   - 000 NEQ ~Z | 001 EQ Z | 010 GT ~Z&~N | 011 LT N
//   - 100 GTE Z|~N | 101 LTE N|Z | 110 OVFL V | 111 UNC 1.
//  Push
//   - Writes the pre-edge registered flags (not this cycle's update) to entry stk_count.
//   - count+1. The same-cycle flag update still applies to the live register.
//  Pop
//   - flags <= entry[stk_count-1]; count-1.
//   - Pop overrides any same-cycle update.
//   - Push and pop are not gated by en.
//  Boundary cases
//   - Push while full: ignored, err_ovf<=1, contents unchanged.
//   - Pop while empty: ignored, err_unf<=1, flags take the normal update.
//   - push&pop same cycle: both ignored, err_ovf<=1 and err_unf<=1.
//   - clr_err: clears both error bits next edge. A same-cycle new error wins (bit stays 1).
//   - Reset mid-sequence: LIFO empties immediately; no partial restore.
// STRUCTURE
//  Package cc_pkg
//   - cond_e enum (NEQ..UNC).
//   - Localparams FLAG_N=2, FLAG_V=1, FLAG_Z=0.
//   - Function cond_eval(cond_e, logic[2:0] nvz).
//  Sub-module cc_flag_stack #(W,DEPTH)
//   - Ports: clk, rst_n, push, pop, din, dout, count, full, empty, ovf, unf.
//   - Contains the pointer and error logic.
//  Top
//   - Flag register, bypass mux, cond_eval, error regs.
// TESTING
//  1. Reset, then en=1 mask=111 in=101: next cycle flags_out=101, cond=001 -> cond_true=1.
//  2. flags=101, mask=010 in=010: flags_out=111 (N,Z kept). en=0 with mask=111 in=000: flags stay 111.
//  3. BYPASS=1, flags=000, en=1 mask=001 in=001, cond=001: cond_true=1 same cycle.
//     Repeat with BYPASS=0: cond_true=0.
//  4. Push 001,010,100,111 (DEPTH=4): stk_full=1. 5th push: err_ovf=1, count=4.
//     Pop x4 restores 111,100,010,001 in order.
//  5. Pop while empty with mask=111 in=110: err_unf=1, flags=110.
//     push&pop same cycle: both errs set, count unchanged.
//     clr_err -> both 0 next cycle.
//  6. Assert rst_n low mid-clock with count=2: flags_out=0, stk_count=0, errors=0 immediately.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and helpers for the condition-code unit.
// Flag bit positions are fixed: N is bit 2, V is bit 1, Z is bit 0.
package cc_pkg;

    typedef enum logic [2:0] {
        COND_NEQ  = 3'b000,
        COND_EQ   = 3'b001,
        COND_GT   = 3'b010,
        COND_LT   = 3'b011,
        COND_GTE  = 3'b100,
        COND_LTE  = 3'b101,
        COND_OVFL = 3'b110,
        COND_UNC  = 3'b111
    } cond_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    function automatic logic cond_eval(cond_e c, logic [2:0] nvz);
        logic n, v, z;
        n = nvz[FLAG_N];
        v = nvz[FLAG_V];
        z = nvz[FLAG_Z];
        case (c)
            COND_NEQ:  return ~z;
            COND_EQ:   return z;
            COND_GT:   return ~z & ~n;
            COND_LT:   return n;
            COND_GTE:  return z | ~n;
            COND_LTE:  return n | z;
            COND_OVFL: return v;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cc_flag_stack.sv
// Save/restore LIFO for flag context: occupancy pointer plus per-cycle error events.
// Push and pop together is treated as a conflict: neither takes effect.
module cc_flag_stack
    import cc_pkg::*;
#(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign ovf     = push & (pop | full);
    assign unf     = pop & (push | empty);
    assign wr_idx  = AW'(count);
    assign rd_idx  = empty ? '0 : AW'(count - CW'(1));
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push_ok) begin
            count <= count + CW'(1);
        end else if (pop_ok) begin
            count <= count - CW'(1);
        end
    end

    // Contents need no reset: the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/cc_flag_unit.sv
// Condition-code unit: masked flag register, branch-condition evaluation with
// optional same-cycle bypass, and a save/restore LIFO with sticky error bits.
module cc_flag_unit
    import cc_pkg::*;
#(
    parameter int NFLAGS = 3,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NFLAGS-1:0]          upd_mask,
    input  logic [NFLAGS-1:0]          flags_in,
    input  logic [2:0]                 cond,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [NFLAGS-1:0]          flags_out,
    output logic                       cond_true,
    output logic [$clog2(DEPTH+1)-1:0] stk_count,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       err_ovf,
    output logic                       err_unf
);

    generate
        if (NFLAGS < 3) begin : g_bad_nflags
            $error("cc_flag_unit: NFLAGS must be at least 3");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("cc_flag_unit: DEPTH must be at least 1");
        end
    endgenerate

    logic [NFLAGS-1:0] merged;
    logic [NFLAGS-1:0] opnd;
    logic [NFLAGS-1:0] stk_dout;
    logic              pop_ok;
    logic              ovf_evt;
    logic              unf_evt;

    assign merged = (flags_out & ~upd_mask) | (flags_in & upd_mask);
    assign pop_ok = pop & ~push & ~stk_empty;

    // The bypass operand follows the raw pop request, so a rejected pop still
    // makes the branch see the registered flags that cycle.
    assign opnd      = ((BYPASS != 0) && en && !pop) ? merged : flags_out;
    assign cond_true = cond_eval(cond_e'(cond),
                                 {opnd[FLAG_N], opnd[FLAG_V], opnd[FLAG_Z]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_out <= '0;
        end else if (pop_ok) begin
            flags_out <= stk_dout;
        end else if (en) begin
            flags_out <= merged;
        end
    end

    // A new error in the same cycle as clr_err keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= ovf_evt | (err_ovf & ~clr_err);
            err_unf <= unf_evt | (err_unf & ~clr_err);
        end
    end

    cc_flag_stack #(
        .W     (NFLAGS),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (flags_out),
        .dout  (stk_dout),
        .count (stk_count),
        .full  (stk_full),
        .empty (stk_empty),
        .ovf   (ovf_evt),
        .unf   (unf_evt)
    );

endmodule

// File: tb/tb_cc_flag_unit.sv
// Scoreboard bench for cc_flag_unit: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor pops and compares against two DUTs (bypass on/off).
module tb_cc_flag_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] upd_mask;
    logic [2:0] flags_in;
    logic [2:0] cond;
    logic       push;
    logic       pop;
    logic       clr_err;

    logic [2:0] flags_out, flags_out_nb;
    logic       cond_true, cond_true_nb;
    logic [2:0] stk_count, stk_count_nb;
    logic       stk_full, stk_full_nb;
    logic       stk_empty, stk_empty_nb;
    logic       err_ovf, err_ovf_nb;
    logic       err_unf, err_unf_nb;

    always #5 clk = ~clk;

    cc_flag_unit #(.NFLAGS(3), .DEPTH(DEPTH), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .upd_mask(upd_mask), .flags_in(flags_in),
        .cond(cond), .push(push), .pop(pop), .clr_err(clr_err),
        .flags_out(flags_out), .cond_true(cond_true), .stk_count(stk_count),
        .stk_full(stk_full), .stk_empty(stk_empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    cc_flag_unit #(.NFLAGS(3), .DEPTH(DEPTH), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .en(en), .upd_mask(upd_mask), .flags_in(flags_in),
        .cond(cond), .push(push), .pop(pop), .clr_err(clr_err),
        .flags_out(flags_out_nb), .cond_true(cond_true_nb), .stk_count(stk_count_nb),
        .stk_full(stk_full_nb), .stk_empty(stk_empty_nb), .err_ovf(err_ovf_nb),
        .err_unf(err_unf_nb)
    );

    typedef struct packed {
        logic [2:0] flags;
        logic       ct;
        logic       ct_nb;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] m_flags;
    logic [2:0] m_stk[$];
    logic       m_ovf, m_unf;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Branch truth table on an N,V,Z triple.
    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic drive_idle();
        en = 0; upd_mask = 0; flags_in = 0; cond = 0; push = 0; pop = 0; clr_err = 0;
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic e, input logic [2:0] m, input logic [2:0] fi,
                        input logic [2:0] c, input logic ps, input logic pp, input logic cl);
        exp_t       x;
        logic [2:0] upd;
        int         sz;
        logic       ovf_evt, unf_evt;
        @(posedge clk);
        #1;
        en = e; upd_mask = m; flags_in = fi; cond = c; push = ps; pop = pp; clr_err = cl;
        sz  = m_stk.size();
        upd = (m_flags & ~m) | (fi & m);
        x.flags = m_flags;
        x.ct    = ref_cond(c, (e && !pp) ? upd : m_flags);
        x.ct_nb = ref_cond(c, m_flags);
        x.cnt   = 3'(sz);
        x.full  = (sz == DEPTH);
        x.empty = (sz == 0);
        x.ovf   = m_ovf;
        x.unf   = m_unf;
        exp_q.push_back(x);
        ovf_evt = ps && (pp || sz == DEPTH);
        unf_evt = pp && (ps || sz == 0);
        m_ovf = ovf_evt || (m_ovf && !cl);
        m_unf = unf_evt || (m_unf && !cl);
        if (ps && !pp && sz < DEPTH) begin
            m_stk.push_back(m_flags);
            if (e) m_flags = upd;
        end else if (pp && !ps && sz > 0) begin
            m_flags = m_stk.pop_back();
        end else if (e) begin
            m_flags = upd;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("rst_flags", 8'(flags_out), 8'd0);
        chk("rst_count", 8'(stk_count), 8'd0);
        chk("rst_errs", {6'd0, err_ovf, err_unf}, 8'd0);
        drive_idle();
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("flags_out", 8'(flags_out), 8'(x.flags));
                chk("cond_true", 8'(cond_true), 8'(x.ct));
                chk("cond_true_nobyp", 8'(cond_true_nb), 8'(x.ct_nb));
                chk("flags_out_nobyp", 8'(flags_out_nb), 8'(x.flags));
                chk("stk_count", 8'(stk_count), 8'(x.cnt));
                chk("stk_full", 8'(stk_full), 8'(x.full));
                chk("stk_empty", 8'(stk_empty), 8'(x.empty));
                chk("err_ovf", 8'(err_ovf), 8'(x.ovf));
                chk("err_unf", 8'(err_unf), 8'(x.unf));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        drive_idle();
        model_reset();
        rst_n = 0;
        #3;
        chk("init_flags", 8'(flags_out), 8'd0);
        chk("init_count", 8'(stk_count), 8'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1;

        step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        // Full update then EQ on Z.
        step(1, 3'b111, 3'b101, 3'b001, 0, 0, 0);
        step(0, 3'b000, 3'b000, 3'b001, 0, 0, 0);
        // Partial mask keeps N and Z; stall holds flags.
        step(1, 3'b010, 3'b010, 3'b000, 0, 0, 0);
        step(0, 3'b111, 3'b000, 3'b011, 0, 0, 0);
        // Bypass check from flags=000.
        step(1, 3'b111, 3'b000, 3'b111, 0, 0, 0);
        step(1, 3'b001, 3'b001, 3'b001, 0, 0, 0);
        // Fill the LIFO with 001,010,100,111, then overflow.
        step(1, 3'b111, 3'b001, 3'b000, 0, 0, 0);
        step(1, 3'b111, 3'b010, 3'b000, 1, 0, 0);
        step(1, 3'b111, 3'b100, 3'b000, 1, 0, 0);
        step(1, 3'b111, 3'b111, 3'b000, 1, 0, 0);
        step(1, 3'b111, 3'b000, 3'b000, 1, 0, 0);
        step(0, 3'b000, 3'b000, 3'b000, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 3'b111, 3'b011, 3'(i), 0, 1, 0);
        // Underflow with normal update, then conflicting push/pop, then clear.
        step(1, 3'b111, 3'b110, 3'b000, 0, 1, 1);
        step(0, 3'b000, 3'b000, 3'b000, 1, 1, 0);
        step(0, 3'b000, 3'b000, 3'b000, 0, 0, 1);
        step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        // Clear coinciding with a new error keeps it set.
        step(0, 3'b000, 3'b000, 3'b000, 0, 1, 1);
        step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        // Two entries plus sticky errors, then reset mid-cycle.
        step(0, 3'b000, 3'b000, 3'b000, 1, 0, 0);
        step(1, 3'b111, 3'b011, 3'b000, 1, 0, 0);
        step(0, 3'b000, 3'b000, 3'b000, 1, 1, 0);
        step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        mid_reset();
        step(0, 3'b000, 3'b000, 3'b000, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) mid_reset();
            step($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 3'($urandom),
                 ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 10) == 0);
        end
        step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
